// File: rtl/tex_coord_norm.sv
// rtl/tex_coord_norm.sv - span sequencer emitting signed 16.16 normalized texture coordinates
// Accepts a span request and streams one coordinate per cycle; outputs derive only from registers.
module tex_coord_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_start,
  input  logic [15:0] req_step,
  input  logic [15:0] req_count,
  input  logic [3:0]  req_lengthExp,
  input  logic        req_centre,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_coord,
  output logic        out_last
);

  typedef enum logic {IDLE, RUN} stateType;

  stateType    state;
  logic [15:0] idx;
  logic [15:0] stepReg;
  logic [15:0] remaining;
  logic [3:0]  expReg;
  logic        centreReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 16'd0;
      stepReg   <= 16'd0;
      remaining <= 16'd0;
      expReg    <= 4'd0;
      centreReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An empty span is consumed without disturbing the held output registers.
          if (req_valid && req_count != 16'd0) begin
            idx       <= req_start;
            stepReg   <= req_step;
            remaining <= req_count;
            expReg    <= req_lengthExp;
            centreReg <= req_centre;
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (remaining == 16'd1) begin
              state <= IDLE;
            end else begin
              idx       <= idx + stepReg;
              remaining <= remaining - 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [4:0]  shiftAmt;
  logic [31:0] idxExt;
  logic [31:0] halfTexel;

  // Shift spans 1..16 so the half-texel bit always lands below the integer texel bits.
  assign shiftAmt  = 5'd16 - {1'b0, expReg};
  assign idxExt    = {{16{idx[15]}}, idx};
  assign halfTexel = centreReg ? (32'd1 << (4'd15 - expReg)) : 32'd0;

  assign out_coord = (idxExt << shiftAmt) + halfTexel;
  assign out_last  = (remaining == 16'd1);
  assign out_valid = (state == RUN);
  assign req_ready = (state == IDLE) && !rst;

endmodule
